// File: rtl/sevenseg_pkg.sv
// ---------------------------------------------------------------------------
// sevenseg_pkg
// Shared definitions for the seven-segment display path: ASCII glyph
// constants used by both the message scroller and the sevenseg driver, and
// the message controller state type.
// ---------------------------------------------------------------------------
package sevenseg_pkg;

    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_HYPHEN = 8'h2d;

    // Number of digits on the display (display_0 is the leftmost).
    localparam int unsigned NUM_DIGITS = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMMIT,
        SHOW,
        SCROLL
    } msg_state_t;

endpackage

// File: rtl/seg_msg_scroller_if.sv
// ---------------------------------------------------------------------------
// seg_msg_scroller_if
// Character load stream into the message scroller (valid/ready handshake).
//   load_valid : producer offers a character
//   load_ready : scroller accepts a character this cycle
//   load_char  : ASCII character
//   load_last  : final character of the message
// master = text producer, slave = seg_msg_scroller.
// ---------------------------------------------------------------------------
interface seg_msg_scroller_if;

    logic       load_valid;
    logic       load_ready;
    logic [7:0] load_char;
    logic       load_last;

    modport master (
        output load_valid,
        output load_char,
        output load_last,
        input  load_ready
    );

    modport slave (
        input  load_valid,
        input  load_char,
        input  load_last,
        output load_ready
    );

endinterface

// File: rtl/seg_msg_scroller_strobe_div.sv
// ---------------------------------------------------------------------------
// strobe_div
// Produces a one-cycle tick every DIV enabled cycles.
//   clk, rstn : clock, asynchronous active-low reset
//   clr       : restart the count from zero (wins over hold)
//   hold      : freeze the count; no tick while high
//   tick      : one-cycle pulse on the DIV-th enabled cycle
// ---------------------------------------------------------------------------
module strobe_div #(
    parameter int unsigned DIV = 25_000_000
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic hold,
    output logic tick
);

    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == CW'(DIV - 1));
    assign tick   = w_wrap && !hold && !clr;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (!hold) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/seg_msg_scroller.sv
// ---------------------------------------------------------------------------
// seg_msg_scroller
// Stores an ASCII message (up to MSG_DEPTH characters) received over a
// valid/ready stream and presents it on four digits, either statically
// (len <= 4) or as a right-to-left scrolling window padded with four spaces.
//   clk, rstn          : clock, asynchronous active-low reset
//   load (slave)       : character stream (valid/ready/char/last)
//   pause              : freezes scrolling while high
//   display_0..3       : registered ASCII per digit, display_0 leftmost
//   scrolling          : high while the message scrolls
// ---------------------------------------------------------------------------
module seg_msg_scroller
    import sevenseg_pkg::*;
#(
    parameter int unsigned MSG_DEPTH = 16,
    parameter int unsigned TICK_DIV  = 25_000_000
) (
    input  logic                clk,
    input  logic                rstn,
    seg_msg_scroller_if.slave   load,
    input  logic                pause,
    output logic [7:0]          display_0,
    output logic [7:0]          display_1,
    output logic [7:0]          display_2,
    output logic [7:0]          display_3,
    output logic                scrolling
);

    localparam int unsigned AW = $clog2(MSG_DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned PW = $clog2(MSG_DEPTH + 4);
    // Wide enough for pos + digit index and for the padded length L.
    localparam int unsigned IW = ((PW > LW) ? PW : LW) + 1;

    msg_state_t    r_state;
    msg_state_t    w_next_state;
    logic [7:0]    r_buf  [MSG_DEPTH];
    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_len;
    logic [PW-1:0] r_pos;
    logic [7:0]    r_disp [NUM_DIGITS];
    logic [7:0]    w_disp [NUM_DIGITS];
    logic [IW-1:0] w_win  [NUM_DIGITS];
    logic [IW-1:0] w_seq_len;
    logic          w_xfer;
    logic          w_restart;
    logic          w_append;
    logic          w_commit;
    logic          w_room;
    logic          w_tick;

    assign load.load_ready = (r_state != COMMIT);
    assign w_xfer          = load.load_valid && load.load_ready;
    assign scrolling       = (r_state == SCROLL);
    assign w_room          = (r_wr_ptr < LW'(MSG_DEPTH));
    assign w_seq_len       = IW'(r_len) + IW'(4);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        w_restart    = 1'b0;
        w_append     = 1'b0;
        w_commit     = 1'b0;
        case (r_state)
            IDLE, SHOW, SCROLL: begin
                // A first character always starts a fresh message.
                if (w_xfer) begin
                    w_restart    = 1'b1;
                    w_next_state = load.load_last ? COMMIT : LOAD;
                end
            end
            LOAD: begin
                if (w_xfer) begin
                    w_append = 1'b1;
                    if (load.load_last) w_next_state = COMMIT;
                end
            end
            COMMIT: begin
                w_commit     = 1'b1;
                w_next_state = (r_wr_ptr <= LW'(4)) ? SHOW : SCROLL;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ---------------- scroll step timing ----------------
    strobe_div #(
        .DIV (TICK_DIV)
    ) u_step (
        .clk  (clk),
        .rstn (rstn),
        .clr  (w_commit),
        .hold (pause || !scrolling),
        .tick (w_tick)
    );

    // ---------------- write pointer, length, scroll position ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_len    <= '0;
            r_pos    <= '0;
        end else begin
            if (w_restart) begin
                r_wr_ptr <= LW'(1);
                r_len    <= '0;
            end else if (w_append && w_room) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_commit) begin
                // wr_ptr saturates at MSG_DEPTH, so it already equals min(wr_ptr, MSG_DEPTH).
                r_len <= r_wr_ptr;
                r_pos <= '0;
            end else if (scrolling && w_tick && !w_restart) begin
                r_pos <= (IW'(r_pos) == w_seq_len - IW'(1)) ? '0 : r_pos + 1'b1;
            end
        end
    end

    // NOTE: the character buffer has no reset; its contents are only read
    // below len, which is reset, so clearing the array would buy nothing.
    always_ff @(posedge clk) begin
        if (w_restart) begin
            r_buf[0] <= load.load_char;
        end else if (w_append && w_room) begin
            r_buf[r_wr_ptr[AW-1:0]] <= load.load_char;
        end
    end

    // ---------------- display window ----------------
    // Window index (pos + k) mod L; pos + k < 2L, so one conditional subtract
    // suffices. In SHOW pos is 0, so the same path yields buf[k].
    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_win[k] = IW'(r_pos) + IW'(k);
            if (w_win[k] >= w_seq_len) w_win[k] = w_win[k] - w_seq_len;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            w_disp[k] = ASCII_SPACE;
            case (r_state)
                LOAD, COMMIT: w_disp[k] = ASCII_HYPHEN;
                SHOW, SCROLL: begin
                    if (w_win[k] < IW'(r_len)) w_disp[k] = r_buf[w_win[k][AW-1:0]];
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < NUM_DIGITS; k++) r_disp[k] <= ASCII_SPACE;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) r_disp[k] <= w_disp[k];
        end
    end

    assign display_0 = r_disp[0];
    assign display_1 = r_disp[1];
    assign display_2 = r_disp[2];
    assign display_3 = r_disp[3];

endmodule

// File: tb/tb_seg_msg_scroller.sv
// ---------------------------------------------------------------------------
// tb_seg_msg_scroller
// Self-checking bench for seg_msg_scroller (MSG_DEPTH=16, TICK_DIV=4).
// A behavioural model keeps the received message as a queue, counts active
// scroll cycles and derives the window as S[(steps + k) mod L].
// ---------------------------------------------------------------------------
module tb_seg_msg_scroller;

    localparam int DEPTH = 16;
    localparam int DIV   = 4;

    typedef logic [7:0] bytes_t[$];
    typedef enum {M_IDLE, M_LOADING, M_COMMIT, M_SHOW, M_SCROLL} mode_t;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pause;
    logic [7:0] display_0, display_1, display_2, display_3;
    logic       scrolling;

    seg_msg_scroller_if u_if ();

    seg_msg_scroller #(
        .MSG_DEPTH (DEPTH),
        .TICK_DIV  (DIV)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .load      (u_if),
        .pause     (pause),
        .display_0 (display_0),
        .display_1 (display_1),
        .display_2 (display_2),
        .display_3 (display_3),
        .scrolling (scrolling)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    mode_t      m_mode;
    logic [7:0] m_msg[$];
    int         m_len;
    int         m_active;
    logic [7:0] exp_disp[4];
    bit         exp_disp_valid;

    function automatic void model_reset();
        m_mode   = M_IDLE;
        m_msg.delete();
        m_len    = 0;
        m_active = 0;
        for (int k = 0; k < 4; k++) exp_disp[k] = 8'h20;
        exp_disp_valid = 1'b1;
    endfunction

    // What the display registers capture from the current (pre-edge) state.
    function automatic void model_view();
        int seq_len, step_pos, j;
        exp_disp_valid = 1'b1;
        seq_len  = m_len + 4;
        step_pos = (m_active / DIV) % seq_len;
        for (int k = 0; k < 4; k++) begin
            case (m_mode)
                M_IDLE:    exp_disp[k] = 8'h20;
                M_LOADING: exp_disp[k] = 8'h2d;
                M_COMMIT:  exp_disp_valid = 1'b0;
                M_SHOW:    exp_disp[k] = (k < m_len) ? m_msg[k] : 8'h20;
                default: begin
                    j = (step_pos + k) % seq_len;
                    exp_disp[k] = (j < m_len) ? m_msg[j] : 8'h20;
                end
            endcase
        end
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] c, input bit l,
                                       input bit p, output bit acc);
        model_view();
        acc = v && (m_mode != M_COMMIT);
        case (m_mode)
            M_IDLE, M_SHOW, M_SCROLL: begin
                if (acc) begin
                    m_msg.delete();
                    m_msg.push_back(c);
                    m_mode = l ? M_COMMIT : M_LOADING;
                end else if (m_mode == M_SCROLL && !p) begin
                    m_active++;
                end
            end
            M_LOADING: begin
                if (acc) begin
                    m_msg.push_back(c);
                    if (l) m_mode = M_COMMIT;
                end
            end
            default: begin
                m_len    = (m_msg.size() < DEPTH) ? m_msg.size() : DEPTH;
                m_active = 0;
                m_mode   = (m_len <= 4) ? M_SHOW : M_SCROLL;
            end
        endcase
    endfunction

    // ---------------- driving and comparing ----------------
    task automatic compare_outputs();
        logic [7:0] obs[4];
        obs = '{display_0, display_1, display_2, display_3};
        check("load_ready", u_if.load_ready, (m_mode != M_COMMIT));
        check("scrolling", scrolling, (m_mode == M_SCROLL));
        if (exp_disp_valid) begin
            for (int k = 0; k < 4; k++) check($sformatf("display_%0d", k), obs[k], exp_disp[k]);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] c, input bit l, input bit p, output bit acc);
        u_if.load_valid = v;
        u_if.load_char  = c;
        u_if.load_last  = l;
        pause           = p;
        @(posedge clk);
        model_edge(v, c, l, p, acc);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic idle(input int n, input int pause_pct);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, ($urandom_range(0, 99) < pause_pct), acc);
    endtask

    // Called at a falling edge; pulls reset low mid-cycle, checks the
    // immediate clear, and releases reset on the next falling edge.
    task automatic async_reset();
        u_if.load_valid = 1'b0;
        u_if.load_last  = 1'b0;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic send_msg(input bytes_t chars, input int max_gap, input int reset_at,
                            output int n_acc);
        bit acc;
        int tries;
        n_acc = 0;
        for (int i = 0; i < chars.size(); i++) begin
            if (i == reset_at) begin
                async_reset();
                break;
            end
            if (max_gap > 0) begin
                repeat ($urandom_range(0, max_gap)) step(1'b0, 8'h00, 1'b0, $urandom_range(0, 1), acc);
            end
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 4) begin
                step(1'b1, chars[i], (i == chars.size() - 1), $urandom_range(0, 1), acc);
                tries++;
            end
            if (!acc) check("handshake_timeout", acc, 1'b1);
            else      n_acc++;
        end
    endtask

    function automatic bytes_t to_bytes(input string s);
        bytes_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    initial begin
        bytes_t q;
        int     n_acc;
        int     stall;
        bit     acc;

        u_if.load_valid = 1'b0;
        u_if.load_char  = 8'h00;
        u_if.load_last  = 1'b0;
        pause           = 1'b0;
        rstn            = 1'b1;
        #1 rstn = 1'b0;
        #6;
        model_reset();
        compare_outputs();
        @(negedge clk);
        rstn = 1'b1;

        // Static message.
        send_msg(to_bytes("HI"), 0, -1, n_acc);
        idle(6, 0);

        // Source holds valid across COMMIT; next character restarts.
        send_msg(to_bytes("AB"), 0, -1, n_acc);
        stall = 0;
        acc   = 1'b0;
        for (int i = 0; i < 4 && !acc; i++) begin
            if (!u_if.load_ready) stall++;
            step(1'b1, "X", 1'b0, 1'b0, acc);
        end
        check("stall_cycles", stall, 1);
        step(1'b1, "Y", 1'b1, 1'b0, acc);
        idle(5, 0);

        // Scrolling message with a full wrap, then a pause window.
        send_msg(to_bytes("HELLO"), 0, -1, n_acc);
        idle(45, 0);
        idle(2, 0);
        idle(10, 100);
        idle(20, 0);

        // Overflow: 20 characters into a 16-deep buffer.
        q.delete();
        for (int i = 0; i < 20; i++) q.push_back(8'h30 + 8'(i % 4));
        send_msg(q, 0, -1, n_acc);
        check("ovf_accepted", n_acc, 20);
        idle(90, 0);

        // Reset after 3 of 6 characters, then a fresh short message.
        send_msg(to_bytes("ABCDEF"), 0, 3, n_acc);
        idle(2, 0);
        send_msg(to_bytes("AC"), 0, -1, n_acc);
        idle(6, 0);

        // Randomized messages, gaps, pauses, restarts and resets.
        for (int it = 0; it < 40; it++) begin
            int n;
            int rst_at;
            n = $urandom_range(1, 20);
            q.delete();
            for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(32, 126)));
            rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, n - 1) : -1;
            send_msg(q, 2, rst_at, n_acc);
            idle($urandom_range(0, 50), 25);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
